// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the core-side request/response handshake and the word-wide data
//   memory port of the load/store unit.
//
//   Request  : req_valid, req_ready, req_write, req_size, req_unsigned,
//              req_addr (byte address), req_wdata (right-justified)
//   Response : resp_valid (single-cycle pulse), resp_rdata, resp_err
//   Memory   : mem_address (word index), mem_write, mem_wdata, mem_rdata
//
//   slave  : the load/store unit itself
//   master : the environment (core plus data memory)
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the core's data-memory port. Byte/halfword/word loads
//   and stores arrive on a valid/ready handshake and are turned into
//   word-wide accesses. Sub-word stores are read-modify-write; loads return
//   sign- or zero-extended lanes (little-endian). Misaligned, illegal-size
//   and out-of-range requests get an error response and never touch memory.
//
// Parameters
//   MEM_WORDS : number of 32-bit words in the data memory
//   MEM_LAT   : cycles mem_address is held before mem_rdata is sampled (1..15)
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : load_store_unit_if.slave (request, response and memory signals)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS = 256,
    parameter int MEM_LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_e;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    size_e       size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] wdata_q, wdata_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic        req_err;
    logic [4:0]  lane_shamt;
    logic [31:0] lane_data;
    logic [31:0] lane_mask;
    logic [31:0] lane_new;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    // Request legality, evaluated on the live request fields at acceptance.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        req_err = 1'b0;
        case (size_e'(bus.req_size))
            SZ_HALF: req_err = bus.req_addr[0];
            SZ_WORD: req_err = |bus.req_addr[1:0];
            SZ_BAD:  req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS)) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores. A legal
    // halfword has off_q[0]==0, so the byte-granular shift also serves halves.
    always_comb begin
        lane_shamt = {off_q, 3'b000};
        lane_data  = bus.mem_rdata >> lane_shamt;
        case (size_q)
            SZ_BYTE: begin
                load_ext  = {{24{~unsigned_q & lane_data[7]}}, lane_data[7:0]};
                lane_mask = 32'h0000_00FF << lane_shamt;
                lane_new  = {24'b0, wdata_q[7:0]} << lane_shamt;
            end
            SZ_HALF: begin
                load_ext  = {{16{~unsigned_q & lane_data[15]}}, lane_data[15:0]};
                lane_mask = 32'h0000_FFFF << lane_shamt;
                lane_new  = {16'b0, wdata_q} << lane_shamt;
            end
            default: begin
                load_ext  = bus.mem_rdata;
                lane_mask = 32'h0;
                lane_new  = 32'h0;
            end
        endcase
        merged = (bus.mem_rdata & ~lane_mask) | lane_new;
    end

    // Next-state and registered-output logic. Response and strobe outputs
    // default to 0 so each is a single-cycle pulse in its own state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = 32'h0;
        resp_err_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_write_d   = 1'b0;
        mem_wdata_d   = 32'h0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_address_d = {2'b00, bus.req_addr[31:2]};
                    write_d       = bus.req_write;
                    size_d        = size_e'(bus.req_size);
                    unsigned_d    = bus.req_unsigned;
                    off_d         = bus.req_addr[1:0];
                    wdata_d       = bus.req_wdata[15:0];
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_write && (size_e'(bus.req_size) == SZ_WORD)) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = 4'(MEM_LAT);
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // The edge that takes the counter to zero is the sample edge.
                if (cnt_q == 4'd1) begin
                    if (write_q) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        mem_wdata_d = merged;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_ext;
                    end
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Asynchronous reset clears the strobe immediately, so an access caught
    // mid-flight never produces a write or a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            write_q       <= 1'b0;
            size_q        <= SZ_BYTE;
            unsigned_q    <= 1'b0;
            off_q         <= 2'b00;
            wdata_q       <= 16'h0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0;
            resp_err_q    <= 1'b0;
            mem_address_q <= 32'h0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_address_q <= mem_address_d;
            mem_write_q   <= mem_write_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Self-checking bench for load_store_unit. Holds a word-wide data memory
//   that the DUT drives, and a byte-addressed reference memory updated from
//   the request semantics (bytes written, little-endian assembly on load).
// ---------------------------------------------------------------------------
module tb_load_store_unit;
    localparam int WORDS = 256;
    localparam int LAT   = 2;
    localparam int LIMIT = 24;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(WORDS), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory seen by the DUT: asynchronous read, write on the edge.
    logic [31:0] mem [WORDS];
    logic        pre_en  = 1'b0;
    int          pre_idx = 0;
    logic [31:0] pre_val = 32'h0;

    always @(posedge clk) begin
        if (pre_en)
            mem[8'(pre_idx)] <= pre_val;
        else if (bus.mem_write && (bus.mem_address < WORDS))
            mem[bus.mem_address[7:0]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = (bus.mem_address < WORDS) ? mem[bus.mem_address[7:0]] : 32'hBAD0_BAD0;

    // Reference memory, one entry per byte.
    logic [7:0] ref_b [WORDS*4];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[idx*4+3], ref_b[idx*4+2], ref_b[idx*4+1], ref_b[idx*4]};
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
        for (int k = 0; k < 4; k++) ref_b[idx*4+k] = val[8*k +: 8];
    endtask

    // One complete transaction with full timing and data checks.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] widx;
        logic        e;
        int          n, ba;
        int          exp_resp_cyc, exp_wr_cnt, exp_wr_cyc;
        logic [31:0] exp_rdata, exp_word;
        int          cyc, resp_cyc, wr_cnt, wr_cyc, stray, addr_bad, ready_bad;
        logic        r_err;
        logic [31:0] r_data, wr_data;

        // Reference model.
        widx      = {2'b00, addr[31:2]};
        e         = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
                    (sz == 2'b10 && addr[1:0] != 2'b00) || (widx >= WORDS);
        exp_rdata = 32'h0;
        exp_word  = 32'h0;
        if (e) begin
            exp_resp_cyc = 1;
            exp_wr_cnt   = 0;
            exp_wr_cyc   = 0;
        end else begin
            n  = 1 << sz;
            ba = int'(widx) * 4 + int'(addr[1:0]);
            if (!wr) begin
                for (int k = 0; k < n; k++) exp_rdata[8*k +: 8] = ref_b[ba+k];
                if (!uns && n < 4 && exp_rdata[8*n-1])
                    for (int k = n; k < 4; k++) exp_rdata[8*k +: 8] = 8'hFF;
                exp_resp_cyc = LAT + 1;
                exp_wr_cnt   = 0;
                exp_wr_cyc   = 0;
            end else begin
                for (int k = 0; k < n; k++) ref_b[ba+k] = wd[8*k +: 8];
                exp_word     = ref_word(int'(widx));
                exp_wr_cnt   = 1;
                exp_wr_cyc   = (n == 4) ? 1 : LAT + 1;
                exp_resp_cyc = exp_wr_cyc + 1;
            end
        end

        // Drive and accept.
        @(negedge clk);
        check({tag, " ready_idle"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);

        cyc = 0; resp_cyc = -1; wr_cnt = 0; wr_cyc = -1; stray = 0;
        addr_bad = 0; ready_bad = 0; r_err = 1'bx; r_data = 32'hx; wr_data = 32'hx;
        while (resp_cyc < 0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            // Garbage on the request lines must be ignored while busy.
            bus.req_valid    = 1'b0;
            bus.req_write    = 1'($urandom);
            bus.req_size     = 2'($urandom);
            bus.req_addr     = $urandom;
            bus.req_wdata    = $urandom;
            if (bus.mem_write) begin
                wr_cnt++;
                wr_cyc  = cyc;
                wr_data = bus.mem_wdata;
            end else if (bus.mem_wdata !== 32'h0) begin
                stray++;
            end
            if (bus.mem_address !== widx) addr_bad++;
            if (bus.req_ready) ready_bad++;
            if (bus.resp_valid) begin
                resp_cyc = cyc;
                r_err    = bus.resp_err;
                r_data   = bus.resp_rdata;
            end
        end
        last_rdata = r_data;

        check({tag, " resp_cycle"}, resp_cyc, exp_resp_cyc);
        check({tag, " resp_err"},   {31'b0, r_err}, {31'b0, e});
        check({tag, " resp_rdata"}, r_data, exp_rdata);
        check({tag, " write_count"}, wr_cnt, exp_wr_cnt);
        if (exp_wr_cnt == 1) begin
            check({tag, " write_cycle"}, wr_cyc, exp_wr_cyc);
            check({tag, " write_data"},  wr_data, exp_word);
        end
        check({tag, " wdata_idle"},  stray, 0);
        check({tag, " addr_stable"}, addr_bad, 0);
        check({tag, " ready_busy"},  ready_bad, 0);

        @(negedge clk);
        check({tag, " resp_pulse"},  {31'b0, bus.resp_valid}, 32'd0);
        check({tag, " ready_after"}, {31'b0, bus.req_ready}, 32'd1);
        if (widx < WORDS)
            check({tag, " mem_word"}, mem[widx[7:0]], ref_word(int'(widx)));
    endtask

    initial begin
        int          cyc, n_resp, wr_cnt, resp_cnt, bad;
        int          resp_cyc [2];
        logic [31:0] resp_dat [2];
        logic [15:0] ready_seen;

        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        // Fill memory while reset is held.
        for (int i = 0; i < WORDS; i++) begin
            logic [31:0] v;
            v = $urandom;
            @(negedge clk);
            pre_en  = 1'b1;
            pre_idx = i;
            pre_val = v;
            for (int k = 0; k < 4; k++) ref_b[i*4+k] = v[8*k +: 8];
        end
        @(negedge clk);
        pre_en = 1'b0;

        check("rst ready",       {31'b0, bus.req_ready},  32'd0);
        check("rst resp_valid",  {31'b0, bus.resp_valid}, 32'd0);
        check("rst resp_rdata",  bus.resp_rdata,          32'd0);
        check("rst resp_err",    {31'b0, bus.resp_err},   32'd0);
        check("rst mem_address", bus.mem_address,         32'd0);
        check("rst mem_write",   {31'b0, bus.mem_write},  32'd0);
        check("rst mem_wdata",   bus.mem_wdata,           32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel ready", {31'b0, bus.req_ready}, 32'd1);

        // Directed cases.
        preload(5, 32'h8899AABB);
        run_req("ld_b_s", 1'b0, 2'b00, 1'b0, 32'h15, 32'h0);
        check("ld_b_s value", last_rdata, 32'hFFFFFFAA);
        run_req("ld_b_u", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0);
        check("ld_b_u value", last_rdata, 32'h000000AA);
        run_req("st_h", 1'b1, 2'b01, 1'b0, 32'h16, 32'h1234);
        check("st_h word5", mem[5], 32'h1234AABB);
        run_req("st_w", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        check("st_w word8", mem[8], 32'hDEADBEEF);
        run_req("err_mis",   1'b0, 2'b10, 1'b0, 32'h02,  32'h0);
        run_req("err_range", 1'b1, 2'b00, 1'b0, 32'h400, 32'h55);
        run_req("err_size",  1'b0, 2'b11, 1'b0, 32'h10,  32'h0);
        run_req("ld_h_s",    1'b0, 2'b01, 1'b0, 32'h16,  32'h0);
        run_req("ld_top",    1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);

        // Back-to-back word loads with req_valid held high.
        preload(5, 32'h8899AABB);
        @(negedge clk);
        check("b2b ready_idle", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h14;
        @(posedge clk);
        cyc = 0; n_resp = 0; ready_seen = 16'h0;
        resp_cyc[0] = -1; resp_cyc[1] = -1; resp_dat[0] = 32'hx; resp_dat[1] = 32'hx;
        while (n_resp < 2 && cyc < 15) begin
            @(negedge clk);
            cyc++;
            bus.req_addr = 32'h20;
            ready_seen[cyc] = bus.req_ready;
            if (bus.resp_valid) begin
                resp_cyc[n_resp] = cyc;
                resp_dat[n_resp] = bus.resp_rdata;
                n_resp++;
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b ready_after", {31'b0, bus.req_ready}, 32'd1);
        check("b2b resp0_cycle", resp_cyc[0], LAT + 1);
        check("b2b resp0_data",  resp_dat[0], 32'h8899AABB);
        check("b2b resp1_cycle", resp_cyc[1], 2 * LAT + 3);
        check("b2b resp1_data",  resp_dat[1], 32'hDEADBEEF);
        check("b2b ready_trace", {16'h0, ready_seen}, 32'd1 << (LAT + 2));

        // Reset while a byte store is waiting on its read.
        preload(5, 32'h8899AABB);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h15;
        bus.req_wdata = 32'h77;
        @(posedge clk);
        wr_cnt = 0; resp_cnt = 0; bad = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        wr_cnt   += int'(bus.mem_write);
        resp_cnt += int'(bus.resp_valid);
        @(posedge clk);
        #2 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wr_cnt   += int'(bus.mem_write);
            resp_cnt += int'(bus.resp_valid);
            if (bus.req_ready) bad++;
        end
        check("abort ready_in_reset", bad, 0);
        check("abort mem_address",    bus.mem_address, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wr_cnt   += int'(bus.mem_write);
            resp_cnt += int'(bus.resp_valid);
            if (!bus.req_ready) bad++;
        end
        check("abort write_count", wr_cnt, 0);
        check("abort resp_count",  resp_cnt, 0);
        check("abort ready_after", bad, 0);
        check("abort word5",       mem[5], 32'h8899AABB);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          r;
            r  = int'($urandom_range(0, 9));
            sz = (r == 0) ? 2'b11 : 2'(r % 3);
            if ($urandom_range(0, 9) < 8)
                a = {22'h0, 8'($urandom_range(0, WORDS - 1)), 2'($urandom)};
            else
                a = $urandom;
            run_req($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        // Whole-memory sweep against the reference.
        bad = 0;
        for (int i = 0; i < WORDS; i++)
            if (mem[i] !== ref_word(i)) bad++;
        check("final mem_sweep", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
